// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access master and its latency counter.
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int LAT_CNT_W      = 4;

    localparam logic [31:0] ROM_BASE = 32'h0040_0000;
    localparam logic [31:0] RAM_BASE = 32'h1001_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_state_e;

    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Load/decrement counter that flags the last cycle of a read-latency window.
module mem_lat_counter
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [LAT_CNT_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 last_o
);

    logic [LAT_CNT_W-1:0] cnt_q;
    logic [LAT_CNT_W-1:0] cnt_d;

    // next count: load wins over decrement, and the count never wraps below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {LAT_CNT_W{1'b0}})) begin
            cnt_d = cnt_q - {{(LAT_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {LAT_CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == {{(LAT_CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mem_access_master.sv
// Single-outstanding load/store initiator toward a fixed-latency synchronous memory.
// Optional build macro: MEM_ALIGN_CHECK_EN (reject misaligned requests with rsp_err_o).
module mem_access_master
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [LAT_CNT_W-1:0]  RD_LAT_C    = LAT_CNT_W'(RD_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK_C = ~ADDR_WIDTH'(2'b11);

    mem_state_e            state_q, state_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  cnt_load_s;
    logic                  cnt_dec_s;
    logic                  cnt_last_s;

    mem_lat_counter u_lat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load_s),
        .load_val_i (RD_LAT_C),
        .dec_i      (cnt_dec_s),
        .last_o     (cnt_last_s)
    );

    // next-state and output-register logic; the latched request lives in the mem_* registers
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
`ifdef MEM_ALIGN_CHECK_EN
                    if (addr_misaligned(req_addr_i[1:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        state_d     = ISSUE;
                        mem_we_d    = req_we_i;
                        mem_addr_d  = req_addr_i;
                        mem_wdata_d = req_wdata_i;
                    end
`else
                    state_d     = ISSUE;
                    mem_we_d    = req_we_i;
                    mem_addr_d  = req_addr_i & WORD_MASK_C;
                    mem_wdata_d = req_wdata_i;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                mem_we_d = 1'b0;
                if (mem_we_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d    = WAIT;
                    cnt_load_s = 1'b1;
                end
            end
            WAIT: begin
                cnt_dec_s = 1'b1;
                // read data is only valid at the edge that ends the latency window
                if (cnt_last_s) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_rdata_i;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_we_d    = 1'b0;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q <= {DATA_WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: two instances (read latency 1 and 3) share stimulus and are
// checked every cycle against a transaction-timeline model; honours MEM_ALIGN_CHECK_EN.
module tb_mem_access_master;
    import mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic [31:0] mem_rdata;
    logic        rd_ramp;
    logic        chk_en;

    int vectors;
    int miscompares;

    logic        d_ready  [2];
    logic        d_valid  [2];
    logic [31:0] d_rdata  [2];
    logic        d_err    [2];
    logic        d_we     [2];
    logic [31:0] d_addr   [2];
    logic [31:0] d_wdata  [2];

    logic        l1_ready, l1_valid, l1_err, l1_we;
    logic [31:0] l1_rdata, l1_addr, l1_wdata;
    logic        l3_ready, l3_valid, l3_err, l3_we;
    logic [31:0] l3_rdata, l3_addr, l3_wdata;

    mem_access_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(l1_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(l1_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(l1_rdata), .rsp_err_o(l1_err),
        .mem_we_o(l1_we), .mem_addr_o(l1_addr), .mem_wdata_o(l1_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_access_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(l3_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(l3_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(l3_rdata), .rsp_err_o(l3_err),
        .mem_we_o(l3_we), .mem_addr_o(l3_addr), .mem_wdata_o(l3_wdata), .mem_rdata_i(mem_rdata)
    );

    assign d_ready[0] = l1_ready;  assign d_ready[1] = l3_ready;
    assign d_valid[0] = l1_valid;  assign d_valid[1] = l3_valid;
    assign d_rdata[0] = l1_rdata;  assign d_rdata[1] = l3_rdata;
    assign d_err[0]   = l1_err;    assign d_err[1]   = l3_err;
    assign d_we[0]    = l1_we;     assign d_we[1]    = l3_we;
    assign d_addr[0]  = l1_addr;   assign d_addr[1]  = l3_addr;
    assign d_wdata[0] = l1_wdata;  assign d_wdata[1] = l3_wdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: each instance holds at most one transaction; timing is measured in edges since accept.
    int          cyc;
    logic        m_busy  [2];
    int          m_acc   [2];
    logic        m_ld    [2];
    logic        m_valid [2];
    logic        m_err   [2];
    logic [31:0] m_rdata [2];
    logic        m_mwe   [2];
    logic [31:0] m_maddr [2];
    logic [31:0] m_mwdata[2];

    function automatic int rsp_edge(input int idx, input logic is_load);
        int lat;
        lat = (idx == 0) ? 1 : 3;
        return is_load ? (1 + lat) : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            for (int i = 0; i < 2; i++) begin
                m_busy[i]   <= 1'b0;
                m_acc[i]    <= 0;
                m_ld[i]     <= 1'b0;
                m_valid[i]  <= 1'b0;
                m_err[i]    <= 1'b0;
                m_rdata[i]  <= 32'h0;
                m_mwe[i]    <= 1'b0;
                m_maddr[i]  <= 32'h0;
                m_mwdata[i] <= 32'h0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 2; i++) begin
                m_mwe[i] <= 1'b0;
                if (m_busy[i]) begin
                    if (m_valid[i]) begin
                        if (rsp_ready) begin
                            m_busy[i]  <= 1'b0;
                            m_valid[i] <= 1'b0;
                            m_err[i]   <= 1'b0;
                        end
                    end else if ((cyc + 1 - m_acc[i]) == rsp_edge(i, m_ld[i])) begin
                        m_valid[i] <= 1'b1;
                        m_rdata[i] <= m_ld[i] ? mem_rdata : 32'h0;
                    end
                end else if (req_valid) begin
                    m_busy[i] <= 1'b1;
                    m_acc[i]  <= cyc + 1;
                    m_ld[i]   <= ~req_we;
`ifdef MEM_ALIGN_CHECK_EN
                    if (req_addr[1:0] != 2'b00) begin
                        m_valid[i] <= 1'b1;
                        m_err[i]   <= 1'b1;
                        m_rdata[i] <= 32'h0;
                    end else begin
                        m_mwe[i]    <= req_we;
                        m_maddr[i]  <= req_addr;
                        m_mwdata[i] <= req_wdata;
                    end
`else
                    m_mwe[i]    <= req_we;
                    m_maddr[i]  <= req_addr & 32'hFFFF_FFFC;
                    m_mwdata[i] <= req_wdata;
`endif
                end
            end
        end
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, act, exp);
        end
    endtask

    // per-cycle compare of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("req_ready", i, {31'h0, d_ready[i]}, {31'h0, ~m_busy[i]});
                chk("rsp_valid", i, {31'h0, d_valid[i]}, {31'h0, m_valid[i]});
                chk("rsp_err",   i, {31'h0, d_err[i]},   {31'h0, m_err[i]});
                chk("mem_we",    i, {31'h0, d_we[i]},    {31'h0, m_mwe[i]});
                chk("mem_addr",  i, d_addr[i],  m_maddr[i]);
                chk("mem_wdata", i, d_wdata[i], m_mwdata[i]);
                if (m_valid[i]) begin
                    chk("rsp_rdata", i, d_rdata[i], m_rdata[i]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (rd_ramp) begin
            mem_rdata = mem_rdata + 32'd1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy[0] || m_busy[1]) && (n < 100)) begin
            tick();
            n++;
        end
        if (m_busy[0] || m_busy[1]) begin
            miscompares++;
            $display("FAIL wait_idle: busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        wait_idle();
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        rst_n       = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        rsp_ready   = 1'b1;
        mem_rdata   = 32'h0;
        rd_ramp     = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        tick();
        chk("rst_ready", 0, {31'h0, d_ready[0]}, 32'h1);
        chk("rst_valid", 1, {31'h0, d_valid[1]}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // store, one-cycle write strobe, response one edge later
        send(1'b1, RAM_BASE + 32'h4, 32'hDEAD_BEEF);
        chk("st_we",    0, {31'h0, d_we[0]}, 32'h1);
        chk("st_addr",  0, d_addr[0],  32'h1001_0004);
        chk("st_wdata", 0, d_wdata[0], 32'hDEAD_BEEF);
        tick();
        chk("st_we_off", 0, {31'h0, d_we[0]}, 32'h0);
        chk("st_valid",  0, {31'h0, d_valid[0]}, 32'h1);
        chk("st_rdata",  0, d_rdata[0], 32'h0);
        wait_idle();

        // load, latency 1 instance answers at accept+2
        mem_rdata = 32'h2008_0005;
        send(1'b0, ROM_BASE + 32'h8, 32'h0);
        tick();
        chk("ld1_early", 0, {31'h0, d_valid[0]}, 32'h0);
        tick();
        chk("ld1_valid", 0, {31'h0, d_valid[0]}, 32'h1);
        chk("ld1_rdata", 0, d_rdata[0], 32'h2008_0005);
        wait_idle();
        chk("ld1_model", 0, m_rdata[0], 32'h2008_0005);

        // read data ramps each cycle; only the capture-edge value may be taken
        mem_rdata = 32'hA000_0000;
        rd_ramp   = 1'b1;
        send(1'b0, ROM_BASE + 32'hC, 32'h0);
        wait_idle();
        rd_ramp = 1'b0;
        chk("ramp_model", 0, m_rdata[0], 32'hA000_0002);
        chk("ramp_model", 1, m_rdata[1], 32'hA000_0004);

        // response back-pressure with a competing request held on the bus
        rsp_ready = 1'b0;
        mem_rdata = 32'h3C3C_0001;
        send(1'b0, RAM_BASE + 32'h20, 32'h0);
        repeat (6) tick();
        req_we    = 1'b1;
        req_addr  = RAM_BASE + 32'h10;
        req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        repeat (5) tick();
        chk("bp_ready", 1, {31'h0, d_ready[1]}, 32'h0);
        chk("bp_valid", 1, {31'h0, d_valid[1]}, 32'h1);
        chk("bp_rdata", 1, d_rdata[1], 32'h3C3C_0001);
        rsp_ready = 1'b1;
        tick();
        chk("bp_done", 0, {31'h0, d_valid[0]}, 32'h0);
        chk("bp_idle", 0, {31'h0, d_ready[0]}, 32'h1);
        tick();
        req_valid = 1'b0;
        chk("bp_acc_we",   0, {31'h0, d_we[0]}, 32'h1);
        chk("bp_acc_addr", 0, d_addr[0], 32'h1001_0010);
        wait_idle();

        // asynchronous reset while waiting on read data
        mem_rdata = 32'h7777_0000;
        send(1'b0, ROM_BASE + 32'h10, 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("mid_rst_valid", i, {31'h0, d_valid[i]}, 32'h0);
            chk("mid_rst_addr",  i, d_addr[i], 32'h0);
            chk("mid_rst_ready", i, {31'h0, d_ready[i]}, 32'h1);
        end
        tick();
        rst_n = 1'b1;
        tick();
        mem_rdata = 32'h5555_AAAA;
        send(1'b0, ROM_BASE + 32'h4, 32'h0);
        wait_idle();
        chk("post_rst_model", 1, m_rdata[1], 32'h5555_AAAA);

        // misaligned load
        send(1'b0, RAM_BASE + 32'h2, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_err",   0, {31'h0, d_err[0]}, 32'h1);
        chk("mis_valid", 0, {31'h0, d_valid[0]}, 32'h1);
        chk("mis_we",    0, {31'h0, d_we[0]}, 32'h0);
        chk("mis_addr",  0, d_addr[0], 32'h0040_0004);
`else
        chk("mis_addr", 0, d_addr[0], 32'h1001_0000);
        chk("mis_err",  0, {31'h0, d_err[0]}, 32'h0);
`endif
        wait_idle();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
